// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
//   Shared types and constants for the three-master SRAM arbiter.
//   - state_t  : transfer state machine encoding (IDLE/ACC1/CAP1/ACC2/CAP2)
//   - NPORTS   : number of bus masters (CPU, blitter, DSP)
//   - req_t    : a latched request {addr, wr, word, wdata}
//   - rr_next  : successor of a port index in round-robin order
package sram_arbiter_pkg;

  localparam int NPORTS   = 3;
  // Width of the address field carried in req_t; the top module keeps only
  // its own ADDR_WIDTH low bits of it meaningful.
  localparam int ADDR_MAX = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    CAP1 = 3'd2,
    ACC2 = 3'd3,
    CAP2 = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic                wr;
    logic                word;
    logic [15:0]         wdata;
  } req_t;

  // Next port after idx, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// sram_rr_pick
//   Combinational 3-way round-robin picker. Search starts at the port after
//   the last grant and wraps.
//   Ports:
//     elig  in  3 : ports allowed to be granted this cycle
//     last  in  2 : index of the most recently granted port
//     gnt   out 3 : one-hot grant (all zero when nothing is eligible)
//     valid out 1 : a grant was made
module sram_rr_pick
  import sram_arbiter_pkg::*;
(
  input  logic [NPORTS-1:0] elig,
  input  logic [1:0]        last,
  output logic [NPORTS-1:0] gnt,
  output logic              valid
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  assign c0 = rr_next(last);
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    if (elig[c0]) begin
      gnt[c0] = 1'b1;
      valid   = 1'b1;
    end else if (elig[c1]) begin
      gnt[c1] = 1'b1;
      valid   = 1'b1;
    end else if (elig[c2]) begin
      gnt[c2] = 1'b1;
      valid   = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 16-bit byte-laned SRAM between three masters (0 CPU,
//   1 blitter, 2 DSP) with round-robin arbitration. Misaligned word requests
//   are split into two byte accesses (odd lane of word n, even lane of n+1).
//   Ports:
//     clk, reset_n                   clock, asynchronous active-low reset
//     req[2:0]                       per-port request, held until ack
//     addrN / wrN / wordN / wdataN   per-port byte address, write, size, data
//     ack[2:0]                       one-cycle completion pulse per port
//     rdataN                         read result, valid from the ack cycle
//     sram_cs/oe/wr/even/odd         SRAM controls (even/odd = byte lane)
//     sram_addr / sram_din / sram_q  SRAM word address, write/read data
module sram_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int NPORTS     = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NPORTS-1:0]     req,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic                  wr2,
  input  logic                  word0,
  input  logic                  word1,
  input  logic                  word2,
  input  logic [15:0]           wdata0,
  input  logic [15:0]           wdata1,
  input  logic [15:0]           wdata2,
  output logic [NPORTS-1:0]     ack,
  output logic [15:0]           rdata0,
  output logic [15:0]           rdata1,
  output logic [15:0]           rdata2,
  output logic                  sram_cs,
  output logic                  sram_oe,
  output logic                  sram_wr,
  output logic                  sram_even,
  output logic                  sram_odd,
  output logic [ADDR_WIDTH-2:0] sram_addr,
  output logic [15:0]           sram_din,
  input  logic [15:0]           sram_q
);

  import sram_arbiter_pkg::*;

  localparam int WA = ADDR_WIDTH - 1;

  // Per-port request views
  logic [ADDR_WIDTH-1:0] addr_arr  [NPORTS];
  logic [NPORTS-1:0]     wr_arr;
  logic [NPORTS-1:0]     word_arr;
  logic [15:0]           wdata_arr [NPORTS];
  req_t                  req_in    [NPORTS];
  logic [15:0]           rdata_reg [NPORTS];

  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign addr_arr[2]  = addr2;
  assign wr_arr       = {wr2, wr1, wr0};
  assign word_arr     = {word2, word1, word0};
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;
  assign wdata_arr[2] = wdata2;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      assign req_in[gi].addr  = ADDR_MAX'(addr_arr[gi]);
      assign req_in[gi].wr    = wr_arr[gi];
      assign req_in[gi].word  = word_arr[gi];
      assign req_in[gi].wdata = wdata_arr[gi];
    end
  endgenerate

  assign rdata0 = rdata_reg[0];
  assign rdata1 = rdata_reg[1];
  assign rdata2 = rdata_reg[2];

  // State
  state_t            state_reg;
  state_t            state_next;
  req_t              cur_reg;
  logic [1:0]        gidx_reg;
  logic [1:0]        last_reg;
  logic [NPORTS-1:0] ack_reg;
  logic [7:0]        lo_reg;
  logic              done;

  // Arbitration
  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] pick_gnt;
  logic              pick_valid;
  logic [1:0]        pick_idx;

  // A port acked this cycle still has its old request up; keep it out.
  assign elig = (state_reg == IDLE) ? (req & ~ack_reg) : '0;

  sram_rr_pick u_pick (
    .elig  (elig),
    .last  (last_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign pick_idx = pick_gnt[1] ? 2'd1 : (pick_gnt[2] ? 2'd2 : 2'd0);

  logic              mis;
  logic              phase2;
  logic [ADDR_MAX-1:0] word_base;

  assign mis       = cur_reg.word & cur_reg.addr[0];
  assign phase2    = (state_reg == ACC2) || (state_reg == CAP2);
  assign word_base = cur_reg.addr >> 1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (pick_valid) state_next = ACC1;
      ACC1: begin
        if (!cur_reg.wr)  state_next = CAP1;
        else if (mis)     state_next = ACC2;
        else begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      CAP1: begin
        if (mis) state_next = ACC2;
        else begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      ACC2: begin
        if (!cur_reg.wr) state_next = CAP2;
        else begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      CAP2: begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // SRAM control outputs; everything idles at zero so an asynchronous reset
  // (state forced to IDLE) clears the bus immediately.
  always_comb begin
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_wr   = 1'b0;
    sram_even = 1'b0;
    sram_odd  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (state_reg != IDLE) begin
      sram_cs   = 1'b1;
      sram_addr = WA'(word_base + ADDR_MAX'(phase2));
      if (!cur_reg.word) begin
        sram_even = ~cur_reg.addr[0];
        sram_odd  = cur_reg.addr[0];
      end else if (mis) begin
        // Phase 1 puts the low byte in the odd lane, phase 2 the high byte
        // in the even lane of the next word.
        sram_even = phase2;
        sram_odd  = ~phase2;
      end
      if (state_reg == CAP1 || state_reg == CAP2) begin
        sram_oe = 1'b1;
      end else if (cur_reg.wr) begin
        sram_wr = 1'b1;
        if (cur_reg.word && !mis) sram_din = cur_reg.wdata;
        else if (phase2)          sram_din = {8'h00, cur_reg.wdata[15:8]};
        else                      sram_din = {8'h00, cur_reg.wdata[7:0]};
      end
    end
  end

  // Request latch, pointer, ack and read-data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_reg  <= '0;
      gidx_reg <= 2'd0;
      last_reg <= 2'd2;   // so port 0 wins the first arbitration
      ack_reg  <= '0;
      lo_reg   <= 8'h00;
      for (int i = 0; i < NPORTS; i++) rdata_reg[i] <= 16'h0000;
    end else begin
      ack_reg <= done ? NPORTS'(3'b001 << gidx_reg) : '0;
      if (state_reg == IDLE && pick_valid) begin
        cur_reg  <= req_in[pick_idx];
        gidx_reg <= pick_idx;
        last_reg <= pick_idx;
      end
      if (state_reg == CAP1) begin
        if (mis)               lo_reg <= sram_q[7:0];
        else if (cur_reg.word) rdata_reg[gidx_reg] <= sram_q;
        else                   rdata_reg[gidx_reg] <= {8'h00, sram_q[7:0]};
      end
      if (state_reg == CAP2) begin
        rdata_reg[gidx_reg] <= {sram_q[7:0], lo_reg};
      end
    end
  end

  assign ack = ack_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [16:0] t_addr  [3];
  logic        t_wr    [3];
  logic        t_word  [3];
  logic [15:0] t_wdata [3];
  logic [2:0]  ack;
  logic [15:0] rdata [3];
  logic        sram_cs, sram_oe, sram_wr, sram_even, sram_odd;
  logic [15:0] sram_addr;
  logic [15:0] sram_din;
  logic [15:0] sram_q;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(17), .NPORTS(3)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .addr0(t_addr[0]), .addr1(t_addr[1]), .addr2(t_addr[2]),
    .wr0(t_wr[0]), .wr1(t_wr[1]), .wr2(t_wr[2]),
    .word0(t_word[0]), .word1(t_word[1]), .word2(t_word[2]),
    .wdata0(t_wdata[0]), .wdata1(t_wdata[1]), .wdata2(t_wdata[2]),
    .ack(ack), .rdata0(rdata[0]), .rdata1(rdata[1]), .rdata2(rdata[2]),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_wr(sram_wr),
    .sram_even(sram_even), .sram_odd(sram_odd), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_q(sram_q)
  );

  // SRAM model: byte lanes write/read through [7:0]
  logic [15:0] mem [65536];
  logic [15:0] mw;

  always @(posedge clk) begin
    if (sram_cs && sram_wr) begin
      if (sram_even)     mem[sram_addr][7:0]  <= sram_din[7:0];
      else if (sram_odd) mem[sram_addr][15:8] <= sram_din[7:0];
      else               mem[sram_addr]       <= sram_din;
    end
  end

  always_comb begin
    mw = mem[sram_addr];
    sram_q = 16'h0000;
    if (sram_cs && sram_oe) begin
      if (sram_even)     sram_q = {8'h00, mw[7:0]};
      else if (sram_odd) sram_q = {8'h00, mw[15:8]};
      else               sram_q = mw;
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    req = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Single transaction on one port; returns ack cycle (-1 on timeout).
  // Entered and left just after a rising edge.
  task automatic run_txn(input int p, input logic [16:0] a, input logic w,
                         input logic wd, input logic [15:0] d,
                         output int lat, output logic [15:0] rd);
    t_addr[p] = a; t_wr[p] = w; t_word[p] = wd; t_wdata[p] = d;
    req[p] = 1'b1;
    lat = -1;
    rd = 16'h0000;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ack[p]) begin
        lat = n;
        rd = rdata[p];
        break;
      end
      @(posedge clk); #1;
    end
    req[p] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int p = 0; p < 3; p++) begin
      t_addr[p] = '0; t_wr[p] = 1'b0; t_word[p] = 1'b0; t_wdata[p] = '0;
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if ({ack, sram_cs, sram_oe, sram_wr, sram_even, sram_odd} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got ack=%b cs=%b oe=%b wr=%b expected all 0", ack, sram_cs, sram_oe, sram_wr);
    end
    checks++;
    if (rdata[0] !== 16'h0 || rdata[1] !== 16'h0 || rdata[2] !== 16'h0) begin
      failures++;
      $display("FAIL reset_rdata got %h %h %h expected 0000", rdata[0], rdata[1], rdata[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    int lat; logic [15:0] rd;
    run_txn(0, 17'h00010, 1'b1, 1'b1, 16'hBEEF, lat, rd);
    $display("txn p0 write word 00010=BEEF ack_cycle=%0d", lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL aligned_wr_lat got %0d expected 2", lat); end
    checks++;
    if (mem[16'h0008] !== 16'hBEEF) begin failures++; $display("FAIL aligned_wr_mem got %h expected BEEF", mem[16'h0008]); end
    run_txn(0, 17'h00010, 1'b0, 1'b1, 16'h0000, lat, rd);
    $display("txn p0 read word 00010 ack_cycle=%0d rdata=%h", lat, rd);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL aligned_rd_lat got %0d expected 3", lat); end
    checks++;
    if (rd !== 16'hBEEF) begin failures++; $display("FAIL aligned_rd_data got %h expected BEEF", rd); end
  endtask

  task automatic test_byte();
    int lat; logic [15:0] rd;
    run_txn(1, 17'h00011, 1'b1, 1'b0, 16'hFF12, lat, rd);
    $display("txn p1 write byte 00011=12 ack_cycle=%0d", lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL byte_wr_lat got %0d expected 2", lat); end
    run_txn(2, 17'h00010, 1'b0, 1'b1, 16'h0000, lat, rd);
    $display("txn p2 read word 00010 ack_cycle=%0d rdata=%h", lat, rd);
    checks++;
    if (rd !== 16'h12EF) begin failures++; $display("FAIL byte_merge_word got %h expected 12EF", rd); end
    run_txn(2, 17'h00011, 1'b0, 1'b0, 16'h0000, lat, rd);
    $display("txn p2 read byte 00011 ack_cycle=%0d rdata=%h", lat, rd);
    checks++;
    if (rd !== 16'h0012 || lat !== 3) begin failures++; $display("FAIL byte_rd_odd got %h lat %0d expected 0012 lat 3", rd, lat); end
    run_txn(1, 17'h00010, 1'b0, 1'b0, 16'h0000, lat, rd);
    $display("txn p1 read byte 00010 ack_cycle=%0d rdata=%h", lat, rd);
    checks++;
    if (rd !== 16'h00EF) begin failures++; $display("FAIL byte_rd_even got %h expected 00EF", rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic [15:0] rd;
    run_txn(0, 17'h00021, 1'b1, 1'b1, 16'hA55A, lat, rd);
    $display("txn p0 write word 00021=A55A ack_cycle=%0d", lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL mis_wr_lat got %0d expected 3", lat); end
    checks++;
    if (mem[16'h0010][15:8] !== 8'h5A || mem[16'h0011][7:0] !== 8'hA5) begin
      failures++;
      $display("FAIL mis_wr_mem got %h/%h expected 5A/A5", mem[16'h0010][15:8], mem[16'h0011][7:0]);
    end
    run_txn(0, 17'h00021, 1'b0, 1'b1, 16'h0000, lat, rd);
    $display("txn p0 read word 00021 ack_cycle=%0d rdata=%h", lat, rd);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL mis_rd_lat got %0d expected 5", lat); end
    checks++;
    if (rd !== 16'hA55A) begin failures++; $display("FAIL mis_rd_data got %h expected A55A", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] rd;
    run_txn(2, 17'h1FFFF, 1'b1, 1'b1, 16'h3344, lat, rd);
    $display("txn p2 write word 1FFFF=3344 ack_cycle=%0d", lat);
    checks++;
    if (mem[16'hFFFF][15:8] !== 8'h44 || mem[16'h0000][7:0] !== 8'h33) begin
      failures++;
      $display("FAIL wrap_wr_mem got %h/%h expected 44/33", mem[16'hFFFF][15:8], mem[16'h0000][7:0]);
    end
    run_txn(1, 17'h1FFFF, 1'b0, 1'b1, 16'h0000, lat, rd);
    $display("txn p1 read word 1FFFF ack_cycle=%0d rdata=%h", lat, rd);
    checks++;
    if (rd !== 16'h3344 || lat !== 5) begin failures++; $display("FAIL wrap_rd got %h lat %0d expected 3344 lat 5", rd, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] rd;
    int k;
    for (int p = 0; p < 3; p++) begin
      run_txn(0, 17'(17'h00040 + 2 * p), 1'b1, 1'b1, 16'(16'hC0D0 + p), lat, rd);
    end
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      t_addr[p] = 17'(17'h00040 + 2 * p); t_wr[p] = 1'b0; t_word[p] = 1'b1;
    end
    req = 3'b111;
    k = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        $display("txn rr ack=%b cycle=%0d rdata=%h", ack, n, rdata[k % 3]);
        checks++;
        if (ack !== 3'(3'b001 << (k % 3)) || n != 3 * (k + 1)) begin
          failures++;
          $display("FAIL rr_order got ack=%b cycle=%0d expected ack=%b cycle=%0d", ack, n, 3'(3'b001 << (k % 3)), 3 * (k + 1));
        end
        checks++;
        if (rdata[k % 3] !== 16'(16'hC0D0 + k % 3)) begin
          failures++;
          $display("FAIL rr_data got %h expected %h", rdata[k % 3], 16'(16'hC0D0 + k % 3));
        end
        k++;
        if (k == 6) begin
          req = 3'b000;
          break;
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (k != 6) begin failures++; $display("FAIL rr_count got %0d acks expected 6", k); end
    req = 3'b000;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int first_n;
    logic [2:0] first_ack;
    int noack_bad;
    t_addr[1] = 17'h00040; t_wr[1] = 1'b0; t_word[1] = 1'b1;
    req[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (sram_oe !== 1'b1) begin failures++; $display("FAIL areset_in_cap1 got oe=%b expected 1", sram_oe); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({ack, sram_cs, sram_oe, sram_wr, sram_even, sram_odd} !== 8'h00 || sram_addr !== 16'h0 || sram_din !== 16'h0) begin
      failures++;
      $display("FAIL areset_outputs got ack=%b cs=%b oe=%b addr=%h expected all 0", ack, sram_cs, sram_oe, sram_addr);
    end
    checks++;
    if (rdata[1] !== 16'h0 || rdata[0] !== 16'h0) begin
      failures++;
      $display("FAIL areset_rdata got %h %h expected 0000", rdata[0], rdata[1]);
    end
    req = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    noack_bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack !== 3'b000) noack_bad++;
    end
    checks++;
    if (noack_bad != 0) begin failures++; $display("FAIL areset_no_ack got %0d ack cycles expected 0", noack_bad); end
    @(posedge clk); #1;
    t_addr[1] = 17'h00042; t_wr[1] = 1'b0; t_word[1] = 1'b1;
    t_addr[2] = 17'h00044; t_wr[2] = 1'b0; t_word[2] = 1'b1;
    req = 3'b110;
    first_n = -1;
    first_ack = 3'b000;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        first_n = n;
        first_ack = ack;
        break;
      end
      @(posedge clk); #1;
    end
    req = 3'b000;
    $display("txn post-reset first ack=%b cycle=%0d rdata1=%h", first_ack, first_n, rdata[1]);
    checks++;
    if (first_ack !== 3'b010 || first_n != 3) begin
      failures++;
      $display("FAIL areset_ptr got ack=%b cycle=%0d expected 010 cycle 3", first_ack, first_n);
    end
    checks++;
    if (rdata[1] !== 16'hC0D1) begin failures++; $display("FAIL areset_rd got %h expected C0D1", rdata[1]); end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_byte();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
